// File: rtl/morse_decoder_fifo.sv
// Morse key decoder: edge-detects dot/dash/space keys, decodes ITU codes to ASCII
// and queues results in a show-ahead FIFO with valid/ready handshake.
module morse_decoder_fifo #(
   parameter int MAX_SYMS   = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          dot_inp,
   input  logic                          dash_inp,
   input  logic                          char_space_inp,
   input  logic                          word_space_inp,
   output logic [7:0]                    sout,
   output logic                          sout_valid,
   input  logic                          sout_ready,
   output logic                          code_err,
   output logic                          overrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int CW = $clog2(MAX_SYMS + 1);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {COLLECT, EMIT_CHAR, EMIT_SPACE} state_t;

   state_t              r_state, w_next;
   logic [3:0]          r_key_q, r_key_e, w_keys;
   logic                w_word, w_char, w_dash, w_dot, w_any;
   logic [CW-1:0]       r_sym_cnt;
   logic [MAX_SYMS-1:0] r_pattern;
   logic                r_long, r_space_pend, r_last_space;
   logic [7:0]          w_char_byte, w_push_data;
   logic                w_push, w_err;
   logic [7:0]          r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wptr, r_rptr;
   logic [LW-1:0]       r_level;
   logic                r_overrun, w_full, w_empty, w_pop, w_wr;

   function automatic logic [7:0] f_decode(input logic [CW-1:0] cnt,
                                           input logic [MAX_SYMS-1:0] pat);
      logic [7:0] key;
      f_decode = 8'h3F;
      if (int'(cnt) <= 5 && (pat >> 5) == '0) begin
         key = {cnt[2:0], pat[4:0]};
         case (key)
            8'b001_00000: f_decode = 8'h45; // E
            8'b001_00001: f_decode = 8'h54; // T
            8'b010_00001: f_decode = 8'h41; // A
            8'b010_00000: f_decode = 8'h49; // I
            8'b010_00011: f_decode = 8'h4D; // M
            8'b010_00010: f_decode = 8'h4E; // N
            8'b011_00100: f_decode = 8'h44; // D
            8'b011_00110: f_decode = 8'h47; // G
            8'b011_00101: f_decode = 8'h4B; // K
            8'b011_00111: f_decode = 8'h4F; // O
            8'b011_00010: f_decode = 8'h52; // R
            8'b011_00000: f_decode = 8'h53; // S
            8'b011_00001: f_decode = 8'h55; // U
            8'b011_00011: f_decode = 8'h57; // W
            8'b100_01000: f_decode = 8'h42; // B
            8'b100_01010: f_decode = 8'h43; // C
            8'b100_00010: f_decode = 8'h46; // F
            8'b100_00000: f_decode = 8'h48; // H
            8'b100_00111: f_decode = 8'h4A; // J
            8'b100_00100: f_decode = 8'h4C; // L
            8'b100_00110: f_decode = 8'h50; // P
            8'b100_01101: f_decode = 8'h51; // Q
            8'b100_00001: f_decode = 8'h56; // V
            8'b100_01001: f_decode = 8'h58; // X
            8'b100_01011: f_decode = 8'h59; // Y
            8'b100_01100: f_decode = 8'h5A; // Z
            8'b101_11111: f_decode = 8'h30;
            8'b101_01111: f_decode = 8'h31;
            8'b101_00111: f_decode = 8'h32;
            8'b101_00011: f_decode = 8'h33;
            8'b101_00001: f_decode = 8'h34;
            8'b101_00000: f_decode = 8'h35;
            8'b101_10000: f_decode = 8'h36;
            8'b101_11000: f_decode = 8'h37;
            8'b101_11100: f_decode = 8'h38;
            8'b101_11110: f_decode = 8'h39;
            default:      f_decode = 8'h3F;
         endcase
      end
   endfunction

   // Edge pulses are registered so they act one cycle after the level is first sampled.
   assign w_keys = {word_space_inp, char_space_inp, dash_inp, dot_inp};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_key_q <= '0;
         r_key_e <= '0;
      end else begin
         r_key_q <= w_keys;
         r_key_e <= w_keys & ~r_key_q;
      end
   end

   assign w_word = r_key_e[3];
   assign w_char = r_key_e[2] & ~r_key_e[3];
   assign w_dash = r_key_e[1] & ~|r_key_e[3:2];
   assign w_dot  = r_key_e[0] & ~|r_key_e[3:1];
   assign w_any  = |r_key_e;

   assign w_char_byte = r_long ? 8'h3F : f_decode(r_sym_cnt, r_pattern);

   always_comb begin
      w_next      = r_state;
      w_push      = 1'b0;
      w_push_data = '0;
      w_err       = 1'b0;
      case (r_state)
         COLLECT: begin
            if (w_word) begin
               if (r_sym_cnt != '0)   w_next = EMIT_CHAR;
               else if (!r_last_space) w_next = EMIT_SPACE;
            end else if (w_char && r_sym_cnt != '0) begin
               w_next = EMIT_CHAR;
            end
         end
         EMIT_CHAR: begin
            w_push      = 1'b1;
            w_push_data = w_char_byte;
            w_err       = w_any | (w_char_byte == 8'h3F);
            w_next      = r_space_pend ? EMIT_SPACE : COLLECT;
         end
         EMIT_SPACE: begin
            w_push      = 1'b1;
            w_push_data = 8'h20;
            w_err       = w_any;
            w_next      = COLLECT;
         end
         default: w_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= COLLECT;
         r_sym_cnt    <= '0;
         r_pattern    <= '0;
         r_long       <= 1'b0;
         r_space_pend <= 1'b0;
         r_last_space <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            COLLECT: begin
               if (w_word) begin
                  if (r_sym_cnt != '0) r_space_pend <= 1'b1;
               end else if (!w_char && (w_dash || w_dot)) begin
                  if (r_sym_cnt == CW'(MAX_SYMS)) begin
                     r_long <= 1'b1;
                  end else begin
                     r_pattern <= {r_pattern[MAX_SYMS-2:0], w_dash};
                     r_sym_cnt <= r_sym_cnt + CW'(1);
                  end
               end
            end
            EMIT_CHAR: begin
               r_sym_cnt    <= '0;
               r_pattern    <= '0;
               r_long       <= 1'b0;
               r_last_space <= 1'b0;
            end
            EMIT_SPACE: begin
               r_space_pend <= 1'b0;
               r_last_space <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // A push into a full queue still lands when the head leaves in the same cycle.
   assign w_empty = (r_level == '0);
   assign w_full  = (r_level == LW'(FIFO_DEPTH));
   assign w_pop   = !w_empty && sout_ready;
   assign w_wr    = w_push && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= w_push_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_level   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + LW'(1);
            2'b01:   r_level <= r_level - LW'(1);
            default: ;
         endcase
      end
   end

   assign sout       = w_empty ? 8'h00 : r_mem[r_rptr];
   assign sout_valid = !w_empty;
   assign code_err   = w_err;
   assign overrun    = r_overrun;
   assign fifo_level = r_level;

endmodule

// File: tb/tb_morse_decoder_fifo.sv
// Scoreboard bench for morse_decoder_fifo: a string-table Morse model predicts the
// output bytes; a negedge monitor pops and compares every handshake.
module tb_morse_decoder_fifo;
   localparam int MAX_SYMS   = 6;
   localparam int FIFO_DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst, dot_inp, dash_inp, char_space_inp, word_space_inp, sout_ready;
   logic [7:0] sout;
   logic       sout_valid, code_err, overrun;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;

   always #5 clk = ~clk;

   morse_decoder_fifo #(.MAX_SYMS(MAX_SYMS), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst(rst), .dot_inp(dot_inp), .dash_inp(dash_inp),
      .char_space_inp(char_space_inp), .word_space_inp(word_space_inp),
      .sout(sout), .sout_valid(sout_valid), .sout_ready(sout_ready),
      .code_err(code_err), .overrun(overrun), .fifo_level(fifo_level)
   );

   int n_checks = 0, n_fail = 0;
   int err_seen = 0, err_exp = 0, valid_cycles = 0;
   byte unsigned exp_q[$];
   string syms = "";
   byte unsigned last_push = 8'h00;
   bit drop_next = 1'b0, rand_ready = 1'b0;

   string tbl[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..",
                      ".---", "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.",
                      "...", "-", "..-", "...-", ".--", "-..-", "-.--", "--..",
                      "-----", ".----", "..---", "...--", "....-", ".....", "-....",
                      "--...", "---..", "----."};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic byte unsigned ref_decode(input string s);
      if (s.len() > MAX_SYMS) return 8'h3F;
      foreach (tbl[i]) if (tbl[i] == s) return (i < 26) ? 8'(65 + i) : 8'(48 + i - 26);
      return 8'h3F;
   endfunction

   function automatic void emit(input byte unsigned b);
      if (!drop_next) exp_q.push_back(b);
      last_push = b;
      if (b == 8'h3F) err_exp++;
   endfunction

   // Monitor: compare every accepted head byte against the expected queue.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (code_err) err_seen++;
         if (sout_valid) valid_cycles++;
         if (sout_valid && sout_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_byte: got 0x%0h, expected no output", sout);
            end else begin
               check("sout", sout, exp_q.pop_front());
            end
         end
      end
   end

   initial forever begin
      @(posedge clk); #1;
      if (rand_ready) sout_ready = 1'($urandom_range(0, 1));
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   // Drives one key cycle (w,c,d,t = word,char,dash,dot) and advances the model.
   task automatic pulse(input bit w, input bit c, input bit d, input bit t);
      word_space_inp = w; char_space_inp = c; dash_inp = d; dot_inp = t;
      @(posedge clk); #1;
      word_space_inp = 0; char_space_inp = 0; dash_inp = 0; dot_inp = 0;
      @(posedge clk); #1;
      if (w) begin
         if (syms.len() > 0) begin emit(ref_decode(syms)); syms = ""; emit(8'h20); end
         else if (last_push != 8'h20) emit(8'h20);
      end else if (c) begin
         if (syms.len() > 0) begin emit(ref_decode(syms)); syms = ""; end
      end else if (d) syms = {syms, "-"};
      else if (t) syms = {syms, "."};
      if (w || c) begin repeat (3) @(posedge clk); #1; end
   endtask

   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) pulse(0, 0, s[i] == "-", s[i] == ".");
      pulse(0, 1, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1; dot_inp = 0; dash_inp = 0; char_space_inp = 0; word_space_inp = 0;
      @(posedge clk); @(posedge clk); #1;
      rst = 0;
      syms = ""; last_push = 8'h00; exp_q.delete();
   endtask

   task automatic drain();
      sout_ready = 1;
      for (int i = 0; i < 50 && sout_valid; i++) begin @(posedge clk); #1; end
      check("drain_valid", sout_valid, 0);
   endtask

   initial begin
      sout_ready = 0;
      do_reset();
      check("rst_sout", sout, 8'h00);
      check("rst_valid", sout_valid, 0);
      check("rst_code_err", code_err, 0);
      check("rst_overrun", overrun, 0);
      check("rst_level", fifo_level, 0);

      // 'A' appears for exactly one cycle with ready held high.
      sout_ready = 1; valid_cycles = 0;
      send(".-");
      check("a_valid_cycles", valid_cycles, 1);
      check("a_no_err", err_seen, 0);

      // '0' then space; repeated word gap adds nothing.
      valid_cycles = 0;
      for (int i = 0; i < 5; i++) pulse(0, 0, 1, 0);
      pulse(1, 0, 0, 0);
      pulse(1, 0, 0, 0);
      check("word_valid_cycles", valid_cycles, 2);
      check("word_queue_empty", exp_q.size(), 0);

      // Overlong and non-ITU codes.
      send(".......");
      send(".-.-.-");
      check("bad_err_count", err_seen, err_exp);

      // Overflow with back-pressure.
      sout_ready = 0;
      for (int i = 0; i < 4; i++) send(".");
      drop_next = 1; send("."); drop_next = 0;
      check("ovf_level", fifo_level, 4);
      check("ovf_overrun", overrun, 1);
      drain();

      // Full FIFO with simultaneous push and pop.
      do_reset();
      check("rst_clears_overrun", overrun, 0);
      sout_ready = 0;
      send("."); send("-"); send(".-"); send("-.");
      check("full_level", fifo_level, 4);
      pulse(0, 0, 0, 1); pulse(0, 0, 0, 1);
      char_space_inp = 1; @(posedge clk); #1;
      char_space_inp = 0; @(posedge clk); #1;
      emit(ref_decode(syms)); syms = "";
      sout_ready = 1; @(posedge clk); #1;
      sout_ready = 0;
      check("pushpop_level", fifo_level, 4);
      check("pushpop_overrun", overrun, 0);
      repeat (2) @(posedge clk); #1;
      drain();

      // Same-cycle dot and dash: dash wins.
      pulse(0, 0, 1, 1);
      send("");
      check("prio_queue_empty", exp_q.size(), 0);

      // Reset mid-character discards the partial code.
      pulse(0, 0, 0, 1);
      do_reset();
      sout_ready = 1;
      pulse(0, 1, 0, 0);
      check("midrst_level", fifo_level, 0);
      check("midrst_valid", sout_valid, 0);

      // Randomized traffic with random consumer stalls.
      rand_ready = 1;
      for (int n = 0; n < 80; n++) begin
         int len;
         len = $urandom_range(0, 7);
         for (int j = 0; j < len; j++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)     pulse(0, 0, 1, 1);
            else if (r < 5) pulse(0, 0, 0, 1);
            else            pulse(0, 0, 1, 0);
         end
         for (int i = 0; i < 200 && fifo_level > 2; i++) begin @(posedge clk); #1; end
         if (fifo_level > 2) check("pace_level", fifo_level, 2);
         if ($urandom_range(0, 3) == 0) pulse(1, 0, 0, 0);
         else                           pulse(0, 1, 0, 0);
      end
      rand_ready = 0;
      drain();
      repeat (2) @(posedge clk); #1;
      check("final_queue_empty", exp_q.size(), 0);
      check("final_err_count", err_seen, err_exp);
      check("final_overrun", overrun, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
